// File: rtl/div_ctrl.sv
// Programmable clock divider: clk_out toggles every N clk cycles, with a clean
// stop and divisor changes held back until the next phase boundary.
module div_ctrl #(
   parameter int          WIDTH       = 24,
   parameter int unsigned DEFAULT_DIV = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   // state    | meaning
   // ---------+-------------------------------------------------------------
   // IDLE     | clk_out held low, counter cleared, divisor loads directly
   // RUN      | counting and toggling clk_out every div_q cycles
   // STOPPING | stop seen during a high phase; finish it, then drop to IDLE
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             cfg_err_q, cfg_err_d;

   logic             boundary;
   logic             xfer;
   logic             take_pend;

   // div_q is never zero, so div_q - 1 cannot wrap.
   assign boundary = (state_q != IDLE) && (cnt_q == (div_q - ONE));
   assign xfer     = cfg_valid && !pend_valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         div_q        <= DEF_DIV;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         clk_out_q    <= 1'b0;
         tick_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         clk_out_q    <= clk_out_d;
         tick_q       <= tick_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      clk_out_d    = clk_out_q;
      tick_d       = 1'b0;
      cfg_err_d    = 1'b0;
      take_pend    = 1'b0;

      case (state_q)
         IDLE: begin
            // A value pended on the cycle we dropped into IDLE lands here.
            take_pend = 1'b1;
            if (start) begin
               state_d   = RUN;
               cnt_d     = '0;
               clk_out_d = 1'b0;
            end
         end
         RUN: begin
            if (stop && !clk_out_q) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_out_d = 1'b0;
               take_pend = 1'b1;
            end else begin
               if (boundary) begin
                  cnt_d     = '0;
                  clk_out_d = !clk_out_q;
                  tick_d    = !clk_out_q;
                  take_pend = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
               if (stop) begin
                  state_d = boundary ? IDLE : STOPPING;
               end
            end
         end
         STOPPING: begin
            if (boundary) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_out_d = 1'b0;
               take_pend = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
         end
      endcase

      if (take_pend && pend_valid_q) begin
         div_d        = pend_q;
         pend_valid_d = 1'b0;
      end

      // xfer implies no pending value, so this never races the apply above.
      if (xfer) begin
         if (cfg_div == '0) begin
            cfg_err_d = 1'b1;
         end else if (state_q == IDLE) begin
            div_d = cfg_div;
         end else begin
            pend_d       = cfg_div;
            pend_valid_d = 1'b1;
         end
      end
   end

   assign cfg_ready = !pend_valid_q;
   assign cfg_err   = cfg_err_q;
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;
   assign running   = (state_q != IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: IDLE config vectors from a table, then timed run/stop/
// reconfigure/reset sequences checked against a queue of expected toggles.
module tb_div_ctrl;

   localparam int W = 24;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_ready, cfg_err, clk_out, tick, running;

   div_ctrl #(.WIDTH(W), .DEFAULT_DIV(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .running   (running)
   );

   always #50 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int   cyc;
      logic val;
   } edge_t;

   edge_t exp_q[$];
   logic  mon_en  = 1'b1;
   logic  prev_co = 1'b0;

   // Outputs are all registered, so sampling on the falling edge is race-free.
   always @(negedge clk) begin
      if (mon_en && reset) begin
         chk("tick", int'(tick), int'(clk_out && !prev_co));
         if (clk_out !== prev_co) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_toggle", int'(clk_out), int'(prev_co));
            end else begin
               edge_t e;
               e = exp_q.pop_front();
               chk("toggle_cycle", cyc, e.cyc);
               chk("toggle_value", int'(clk_out), int'(e.val));
            end
         end
      end
      prev_co = clk_out;
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push(input int c, input logic v);
      edge_t e;
      e.cyc = c;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_clk_out"}, int'(clk_out), 0);
      chk({tag, "_tick"}, int'(tick), 0);
      chk({tag, "_cfg_err"}, int'(cfg_err), 0);
      chk({tag, "_running"}, int'(running), 0);
      chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
   endtask

   typedef struct {
      logic         cv;
      logic [W-1:0] div;
      logic         st;
      logic         sp;
      logic         exp_ready;
      logic         exp_err;
      logic         exp_run;
   } vec_t;

   vec_t vecs[5];

   int e;

   initial begin
      vecs[0] = '{1'b1, 24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 24'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check_idle_outputs("in_reset");
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("after_release");

      // IDLE config vectors: rejection of 0, stop ignored, load of 3.
      for (int i = 0; i < 5; i++) begin
         cfg_valid = vecs[i].cv;
         cfg_div   = vecs[i].div;
         start     = vecs[i].st;
         stop      = vecs[i].sp;
         @(negedge clk);
         cfg_valid = 1'b0;
         start     = 1'b0;
         stop      = 1'b0;
         chk($sformatf("vec%0d_ready", i), int'(cfg_ready), int'(vecs[i].exp_ready));
         chk($sformatf("vec%0d_err", i), int'(cfg_err), int'(vecs[i].exp_err));
         chk($sformatf("vec%0d_run", i), int'(running), int'(vecs[i].exp_run));
      end

      // N=3 run, reconfigure to 5 mid-high-phase, reject 0 in RUN, stop low.
      start = 1'b1;
      e = cyc + 1;
      push(e + 3, 1'b1);
      push(e + 6, 1'b0);
      push(e + 11, 1'b1);
      push(e + 16, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("A_running", int'(running), 1);
      chk("A_clk_low_at_entry", int'(clk_out), 0);
      wait_cyc(e + 4);
      cfg_valid = 1'b1;
      cfg_div   = 24'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("A_ready_low_pending", int'(cfg_ready), 0);
      wait_cyc(e + 6);
      chk("A_ready_back", int'(cfg_ready), 1);
      wait_cyc(e + 12);
      cfg_valid = 1'b1;
      cfg_div   = 24'd0;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("A_err_run", int'(cfg_err), 1);
      chk("A_ready_after_err", int'(cfg_ready), 1);
      @(negedge clk);
      chk("A_err_one_cycle", int'(cfg_err), 0);
      wait_cyc(e + 17);
      chk("A_running_before_stop", int'(running), 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("A_idle_after_low_stop", int'(running), 0);
      repeat (8) @(negedge clk);
      chk("A_queue_drained", exp_q.size(), 0);

      // N=4, stop during high phase finishes the phase before IDLE.
      cfg_valid = 1'b1;
      cfg_div   = 24'd4;
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b1;
      e = cyc + 1;
      push(e + 4, 1'b1);
      push(e + 8, 1'b0);
      push(e + 12, 1'b1);
      push(e + 16, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(e + 13);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("B_running_stopping", int'(running), 1);
      wait_cyc(e + 15);
      chk("B_still_high", int'(clk_out), 1);
      chk("B_running_late", int'(running), 1);
      @(negedge clk);
      chk("B_idle_after_fall", int'(running), 0);
      repeat (6) @(negedge clk);
      chk("B_queue_drained", exp_q.size(), 0);

      // Reset mid-high-phase with a pending value; DEFAULT_DIV=7 afterwards.
      start = 1'b1;
      e = cyc + 1;
      push(e + 4, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(e + 5);
      cfg_valid = 1'b1;
      cfg_div   = 24'd9;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("C_ready_low", int'(cfg_ready), 0);
      chk("C_high_before_reset", int'(clk_out), 1);
      chk("C_queue_before_reset", exp_q.size(), 0);
      mon_en = 1'b0;
      #10 reset = 1'b0;
      #1;
      chk("C_async_clk_low", int'(clk_out), 0);
      chk("C_async_running", int'(running), 0);
      chk("C_async_ready", int'(cfg_ready), 1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      check_idle_outputs("C_post_reset");
      start = 1'b1;
      e = cyc + 1;
      push(e + 7, 1'b1);
      push(e + 14, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(e + 15);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("C_idle", int'(running), 0);
      repeat (10) @(negedge clk);
      chk("C_queue_drained", exp_q.size(), 0);

      // N=2, transfer of 6 exactly on a boundary: one more 2-cycle phase.
      cfg_valid = 1'b1;
      cfg_div   = 24'd2;
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b1;
      e = cyc + 1;
      push(e + 2, 1'b1);
      push(e + 4, 1'b0);
      push(e + 6, 1'b1);
      push(e + 12, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(e + 3);
      cfg_valid = 1'b1;
      cfg_div   = 24'd6;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("D_ready_low_at_bnd", int'(cfg_ready), 0);
      @(negedge clk);
      chk("D_ready_low_next", int'(cfg_ready), 0);
      @(negedge clk);
      chk("D_ready_back", int'(cfg_ready), 1);
      wait_cyc(e + 13);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("D_idle", int'(running), 0);
      repeat (10) @(negedge clk);
      chk("D_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
